regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 132 +++++++++++++
 tb/tb_regfile_mp.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-ported register file: two read ports, a pipeline write port (3), a
// load-return write port (4) and a busy scoreboard with a population count.
// Reads are combinational with optional same-cycle forwarding, or registered
// with the post-write value (READ_REG=1).
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned READ_REG = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wd3,
  input  logic              we3,
  input  logic [ADDR_W-1:0] a4,
  input  logic [DATA_W-1:0] wd4,
  input  logic              we4,
  input  logic              rsv_we,
  input  logic [ADDR_W-1:0] rsv_a,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [Depth];
  logic [Depth-1:0]  r_busy;
  logic [ADDR_W:0]   r_busy_cnt;
  logic [DATA_W-1:0] r_rd1, r_rd2;
  logic              r_busy1, r_busy2;

  logic              w_we3, w_we4, w_rsv;
  logic [Depth-1:0]  w_busy_d;
  logic [ADDR_W:0]   w_busy_cnt_d;
  logic              w_inc, w_dec;
  logic [DATA_W-1:0] w_rd1_post, w_rd2_post, w_rd1_cmb, w_rd2_cmb;
  logic              w_busy1_cmb, w_busy2_cmb;

  // Read value for address a; byp selects same-cycle forwarding of write data.
  function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] a,
                                                 input logic byp);
    if (ZERO_REG != 0 && a == '0) return '0;
    if (byp && w_we3 && a3 == a) return wd3;
    if (byp && w_we4 && a4 == a) return wd4;
    return r_mem[a];
  endfunction

  // Effective enables: reset suppresses everything, address 0 is inert if hardwired.
  always_comb begin
    w_we3 = we3 && !reset && !(ZERO_REG != 0 && a3 == '0);
    w_we4 = we4 && !reset && !(ZERO_REG != 0 && a4 == '0);
    w_rsv = rsv_we && !reset && !(ZERO_REG != 0 && rsv_a == '0);
  end

  // Next busy vector: load return clears, a new reservation wins over a clear.
  always_comb begin
    w_busy_d = r_busy;
    if (w_we4) w_busy_d[a4] = 1'b0;
    if (w_rsv) w_busy_d[rsv_a] = 1'b1;
  end

  // Busy count tracks only real 0->1 and 1->0 transitions of the busy bits.
  always_comb begin
    w_inc        = w_rsv && !r_busy[rsv_a];
    w_dec        = w_we4 && r_busy[a4] && !(w_rsv && rsv_a == a4);
    w_busy_cnt_d = r_busy_cnt;
    if (w_inc && !w_dec) w_busy_cnt_d = r_busy_cnt + 1'b1;
    if (!w_inc && w_dec) w_busy_cnt_d = r_busy_cnt - 1'b1;
  end

  // Read-port values: post-write (registered mode) and combinational mode.
  always_comb begin
    w_rd1_post  = read_val(a1, 1'b1);
    w_rd2_post  = read_val(a2, 1'b1);
    w_rd1_cmb   = read_val(a1, BYPASS != 0);
    w_rd2_cmb   = read_val(a2, BYPASS != 0);
    w_busy1_cmb = r_busy[a1] &&
                  !(BYPASS != 0 && w_we4 && a4 == a1 && !(w_rsv && rsv_a == a1));
    w_busy2_cmb = r_busy[a2] &&
                  !(BYPASS != 0 && w_we4 && a4 == a2 && !(w_rsv && rsv_a == a2));
  end

  // Storage update; port 3 is written last so it wins an address conflict.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(Depth); i++) r_mem[i] <= '0;
    end else begin
      if (w_we4) r_mem[a4] <= wd4;
      if (w_we3) r_mem[a3] <= wd3;
    end
  end

  // Scoreboard state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_d;
      r_busy_cnt <= w_busy_cnt_d;
    end
  end

  // Registered read ports capture the post-write value of the presented address.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_busy1 <= 1'b0;
      r_busy2 <= 1'b0;
    end else begin
      r_rd1   <= w_rd1_post;
      r_rd2   <= w_rd2_post;
      r_busy1 <= w_busy_d[a1];
      r_busy2 <= w_busy_d[a2];
    end
  end

  assign rd1      = (READ_REG != 0) ? r_rd1   : w_rd1_cmb;
  assign rd2      = (READ_REG != 0) ? r_rd2   : w_rd2_cmb;
  assign busy1    = (READ_REG != 0) ? r_busy1 : w_busy1_cmb;
  assign busy2    = (READ_REG != 0) ? r_busy2 : w_busy2_cmb;
  assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a combinational-read instance and a registered-read
// instance share stimulus and are checked against an array-based model.
module tb_regfile_mp;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  a1, a2, a3, a4, rsv_a;
  logic [31:0] wd3, wd4;
  logic        we3, we4, rsv_we;

  logic [31:0] c_rd1, c_rd2, r_rd1, r_rd2;
  logic        c_busy1, c_busy2, r_busy1, r_busy2;
  logic [5:0]  c_cnt, r_cnt;

  int vectors = 0;
  int errs    = 0;

  // Reference state
  logic [31:0] m_mem [32];
  bit          m_busy [32];

  always #5 clock = ~clock;

  regfile_mp u_dut (
    .clock(clock), .reset(reset), .a1(a1), .a2(a2), .rd1(c_rd1), .rd2(c_rd2),
    .a3(a3), .wd3(wd3), .we3(we3), .a4(a4), .wd4(wd4), .we4(we4),
    .rsv_we(rsv_we), .rsv_a(rsv_a), .busy1(c_busy1), .busy2(c_busy2), .busy_cnt(c_cnt)
  );

  regfile_mp #(.READ_REG(1)) u_dut_rr (
    .clock(clock), .reset(reset), .a1(a1), .a2(a2), .rd1(r_rd1), .rd2(r_rd2),
    .a3(a3), .wd3(wd3), .we3(we3), .a4(a4), .wd4(wd4), .we4(we4),
    .rsv_we(rsv_we), .rsv_a(rsv_a), .busy1(r_busy1), .busy2(r_busy2), .busy_cnt(r_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  // What a combinational read port must show right now.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (we3 && a3 == a) return wd3;
    if (we4 && a4 == a) return wd4;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (we4 && a4 == a && !(rsv_we && rsv_a == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = 32'h0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (we4 && a4 != 0) m_mem[a4] = wd4;
      if (we3 && a3 != 0) m_mem[a3] = wd3;
      if (we4) m_busy[a4] = 1'b0;
      if (rsv_we && rsv_a != 0) m_busy[rsv_a] = 1'b1;
    end
  endtask

  // One clock: check combinational outputs, advance the model, check registered ones.
  task automatic step();
    logic [4:0] a1p, a2p;
    #3;
    if (!reset) begin
      chk("c_rd1", c_rd1, exp_rd(a1));
      chk("c_rd2", c_rd2, exp_rd(a2));
      chk("c_busy1", 32'(c_busy1), 32'(exp_busy(a1)));
      chk("c_busy2", 32'(c_busy2), 32'(exp_busy(a2)));
      chk("c_cnt_pre", 32'(c_cnt), 32'(model_cnt()));
    end
    a1p = a1;
    a2p = a2;
    @(posedge clock);
    model_edge();
    #1;
    chk("c_cnt", 32'(c_cnt), 32'(model_cnt()));
    chk("r_cnt", 32'(r_cnt), 32'(model_cnt()));
    chk("r_rd1", r_rd1, (a1p == 0) ? 32'h0 : m_mem[a1p]);
    chk("r_rd2", r_rd2, (a2p == 0) ? 32'h0 : m_mem[a2p]);
    chk("r_busy1", 32'(r_busy1), 32'(a1p != 0 && m_busy[a1p]));
    chk("r_busy2", 32'(r_busy2), 32'(a2p != 0 && m_busy[a2p]));
  endtask

  task automatic idle();
    reset = 0; we3 = 0; we4 = 0; rsv_we = 0;
    a3 = 0; a4 = 0; rsv_a = 0; wd3 = 0; wd4 = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
    idle();
    a1 = 0; a2 = 0;
    reset = 1;
    step();
    step();
    idle();

    // Post-reset sweep of every address
    for (int i = 0; i < 32; i += 2) begin
      a1 = 5'(i); a2 = 5'(i + 1);
      #3;
      chk("rst_sweep_rd1", c_rd1, 32'h0);
      chk("rst_sweep_busy2", 32'(c_busy2), 32'h0);
      step();
    end

    // Same-cycle forwarding then stored value
    we3 = 1; a3 = 5; wd3 = 32'hDEADBEEF; a1 = 5;
    #3; chk("fwd_rd1", c_rd1, 32'hDEADBEEF);
    step();
    we3 = 0;
    #3; chk("stored_rd1", c_rd1, 32'hDEADBEEF);
    step();

    // Port 3 wins a write conflict
    we3 = 1; we4 = 1; a3 = 7; a4 = 7; wd3 = 32'h11111111; wd4 = 32'h22222222; a2 = 7;
    step();
    idle();
    #3; chk("conflict_rd2", c_rd2, 32'h11111111);
    step();

    // Register 0 ignores writes and reservations
    we3 = 1; a3 = 0; wd3 = 32'hFFFFFFFF; rsv_we = 1; rsv_a = 0; a1 = 0;
    step();
    idle();
    #3;
    chk("zero_rd1", c_rd1, 32'h0);
    chk("zero_busy1", 32'(c_busy1), 32'h0);
    chk("zero_cnt", 32'(c_cnt), 32'h0);
    step();

    // Scoreboard sequence
    rsv_we = 1; rsv_a = 3; step();
    rsv_a = 4; step();
    rsv_a = 3; step();
    chk("sb_cnt2", 32'(c_cnt), 32'd2);
    idle(); we4 = 1; a4 = 3; wd4 = 32'h33; step();
    chk("sb_cnt1", 32'(c_cnt), 32'd1);
    idle(); a1 = 3; a2 = 4;
    #3; chk("sb_busy3", 32'(c_busy1), 32'h0);
    step();
    we4 = 1; a4 = 4; wd4 = 32'h44; rsv_we = 1; rsv_a = 4; step();
    idle();
    #3;
    chk("sb_busy4", 32'(c_busy2), 32'h1);
    chk("sb_cnt_hold", 32'(c_cnt), 32'd1);
    step();

    // Registered read latency
    we4 = 1; a4 = 9; wd4 = 32'hA5A5A5A5; a1 = 9;
    #3; chk("rr_not_before", 32'(r_rd1 == 32'hA5A5A5A5), 32'h0);
    step();
    chk("rr_after", r_rd1, 32'hA5A5A5A5);
    idle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      reset  = ($urandom_range(0, 63) == 0);
      we3    = ($urandom_range(0, 2) == 0);
      we4    = ($urandom_range(0, 2) == 0);
      rsv_we = ($urandom_range(0, 2) == 0);
      a1 = 5'($urandom); a2 = 5'($urandom); a3 = 5'($urandom_range(0, 7));
      a4 = 5'($urandom_range(0, 7)); rsv_a = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) a1 = a4;
      if ($urandom_range(0, 3) == 1) a2 = a3;
      wd3 = $urandom; wd4 = $urandom;
      step();
    end
    idle();

    // Fill, reserve, then reset with a write pending
    for (int i = 1; i < 32; i++) begin
      we3 = 1; a3 = 5'(i); wd3 = 32'h1000_0000 | 32'(i);
      rsv_we = (i <= 10); rsv_a = 5'(i);
      step();
    end
    idle();
    chk("pre_rst_cnt", 32'(c_cnt), 32'd10);
    reset = 1; we3 = 1; a3 = 12; wd3 = 32'hCAFEF00D;
    step();
    idle();
    chk("post_rst_cnt", 32'(c_cnt), 32'd0);
    for (int i = 0; i < 32; i += 2) begin
      a1 = 5'(i); a2 = 5'(i + 1);
      #3;
      chk("post_rst_rd1", c_rd1, 32'h0);
      chk("post_rst_rd2", c_rd2, 32'h0);
      chk("post_rst_busy1", 32'(c_busy1), 32'h0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
